// File: rtl/alu_req_issuer_if.sv
// Request, ALU and response channels of the ALU request issuer.
// The master modport is the issuer's view; slave is the controller/ALU side.
interface alu_req_issuer_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic             req_f7b5;
    logic             req_is_imm;
    logic             req_is_lui;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_ctr;
    logic [31:0]      alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        input  req_valid, req_funct3, req_f7b5, req_is_imm, req_is_lui,
               req_a, req_b, req_tag, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctr, rsp_valid, rsp_result,
               rsp_zero, rsp_tag
    );

    modport slave (
        output req_valid, req_funct3, req_f7b5, req_is_imm, req_is_lui,
               req_a, req_b, req_tag, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctr, rsp_valid, rsp_result,
               rsp_zero, rsp_tag
    );
endinterface

// File: rtl/alu_req_issuer.sv
// Issues one RV32I ALU operation at a time: decodes the request, holds the
// ALU operands stable, samples the result after ALU_LAT cycles and returns it.
module alu_req_issuer #(
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_req_issuer_if.master bus,
    output logic             busy,
    output logic [15:0]      op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // One cycle for the registered operands to reach the ALU, then ALU_LAT cycles of hold.
    localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT);

    state_t           state, state_next;
    logic             req_ready, accept, capture, rsp_fire;
    logic [3:0]       cnt;
    logic [31:0]      alu_a, alu_b, rsp_result;
    logic [3:0]       alu_ctr;
    logic [TAG_W-1:0] exec_tag, rsp_tag;
    logic             rsp_valid, rsp_zero;
    logic             unused;

    assign unused = bus.alu_zero;

    function automatic logic [3:0] decode(input logic [2:0] funct3, input logic f7b5,
                                          input logic is_imm, input logic is_lui);
        logic [3:0] code;
        if (is_lui) begin
            code = 4'b1111;
        end else begin
            case (funct3)
                3'b000:  code = (f7b5 && !is_imm) ? 4'b1000 : 4'b0000;
                3'b101:  code = f7b5 ? 4'b1101 : 4'b0101;
                default: code = {1'b0, funct3};
            endcase
        end
        return code;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                req_ready = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    rsp_fire = 1'b1;
                    if (bus.req_valid) begin
                        accept     = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctr    <= '0;
            cnt        <= '0;
            exec_tag   <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_tag    <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                alu_a    <= bus.req_a;
                alu_b    <= bus.req_b;
                alu_ctr  <= decode(bus.req_funct3, bus.req_f7b5, bus.req_is_imm, bus.req_is_lui);
                exec_tag <= bus.req_tag;
                cnt      <= CNT_LOAD;
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            // rsp_zero is derived from the sampled result, not the ALU's own zero flag.
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= bus.alu_result;
                rsp_zero   <= (bus.alu_result == 32'd0);
                rsp_tag    <= exec_tag;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end

            if (rsp_fire) op_count <= op_count + 16'd1;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_ctr    = alu_ctr;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_zero   = rsp_zero;
    assign bus.rsp_tag    = rsp_tag;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_alu_req_issuer.sv
// Directed bench for alu_req_issuer: an ALU_LAT=1 instance with a combinational
// ALU and an ALU_LAT=3 instance with a 3-stage ALU that reads garbage until filled.
module tb_alu_req_issuer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy1, busy3;
    logic [15:0] cnt1, cnt3;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    alu_req_issuer_if #(.TAG_W(4)) if1 ();
    alu_req_issuer_if #(.TAG_W(4)) if3 ();

    alu_req_issuer #(.ALU_LAT(1), .TAG_W(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1), .op_count(cnt1));
    alu_req_issuer #(.ALU_LAT(3), .TAG_W(4)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(if3), .busy(busy3), .op_count(cnt3));

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'd0, $signed(a) < $signed(b)};
            4'b0011: return {31'd0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return 32'($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1111: return b;
            default: return 32'd0;
        endcase
    endfunction

    assign if1.alu_result = alu_f(if1.alu_a, if1.alu_b, if1.alu_ctr);
    assign if1.alu_zero   = ~|if1.alu_result;

    logic [31:0] s1, s2, s3;
    logic [3:0]  age = 4'd15;
    always @(posedge clk) begin
        s1 <= alu_f(if3.alu_a, if3.alu_b, if3.alu_ctr);
        s2 <= s1;
        s3 <= s2;
        if (if3.req_valid && if3.req_ready) age <= 4'd0;
        else if (age != 4'd15)              age <= age + 4'd1;
    end
    assign if3.alu_result = (age >= 4'd3) ? s3 : 32'hDEADBEEF;
    assign if3.alu_zero   = ~|if3.alu_result;

    typedef struct {
        logic [2:0]  f3;
        logic        f7b5, imm, lui;
        logic [31:0] a, b;
        logic [3:0]  ctr;
        logic [31:0] res;
    } vec_t;
    vec_t vecs[5];

    task automatic set_req1(input logic [2:0] f3, input logic f7b5, input logic imm,
                            input logic lui, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag);
        if1.req_funct3 = f3;
        if1.req_f7b5   = f7b5;
        if1.req_is_imm = imm;
        if1.req_is_lui = lui;
        if1.req_a      = a;
        if1.req_b      = b;
        if1.req_tag    = tag;
    endtask

    // Issues one request on the ALU_LAT=1 instance and waits (bounded) for its response.
    task automatic op1(input logic [2:0] f3, input logic f7b5, input logic imm, input logic lui,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       output logic [3:0] ctr, output int lat, output logic [31:0] res,
                       output logic zero, output logic [3:0] rtag);
        logic acc;
        lat = -1; ctr = 'x; res = 'x; zero = 'x; rtag = 'x;
        @(posedge clk); #1;
        set_req1(f3, f7b5, imm, lui, a, b, tag);
        if1.req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk); acc = if1.req_ready;
            @(posedge clk); #1;
        end
        if1.req_valid = 1'b0;
        if (acc) begin
            @(negedge clk); ctr = if1.alu_ctr;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (if1.rsp_valid) begin lat = i; break; end
            end
            res = if1.rsp_result; zero = if1.rsp_zero; rtag = if1.rsp_tag;
        end
    endtask

    task automatic pop1();
        if1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        if1.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if1.req_valid = 1'b0; if1.rsp_ready = 1'b0;
        if3.req_valid = 1'b0; if3.rsp_ready = 1'b0;
        set_req1(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(negedge clk);
        total++; if ({if1.alu_a, if1.alu_b, if1.alu_ctr} !== 68'd0) $display("FAIL reset_alu: got %h want 0", {if1.alu_a, if1.alu_b, if1.alu_ctr}); else passed++;
        total++; if ({if1.rsp_valid, if1.rsp_zero, busy1} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {if1.rsp_valid, if1.rsp_zero, busy1}); else passed++;
        total++; if ({if1.rsp_result, if1.rsp_tag, cnt1} !== 52'd0) $display("FAIL reset_rsp: got %h want 0", {if1.rsp_result, if1.rsp_tag, cnt1}); else passed++;
        total++; if (if1.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", if1.req_ready); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_sub();
        logic [3:0] ctr, rtag; logic [31:0] res; logic zero; int lat;
        op1(3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 4'd3, ctr, lat, res, zero, rtag);
        total++; if (ctr !== 4'b1000) $display("FAIL sub_ctr: got %b want 1000", ctr); else passed++;
        total++; if (lat !== 2) $display("FAIL sub_latency: got %0d want 2", lat); else passed++;
        total++; if ({res, zero, rtag} !== {32'hFFFFFFFE, 1'b0, 4'd3}) $display("FAIL sub_rsp: got %h/%b/%h want fffffffe/0/3", res, zero, rtag); else passed++;
        total++; if (if1.req_ready !== 1'b0) $display("FAIL sub_req_ready_in_resp: got %b want 0", if1.req_ready); else passed++;
        pop1();
        total++; if ({if1.rsp_valid, busy1, cnt1} !== {1'b0, 1'b0, 16'd1}) $display("FAIL sub_after_pop: got v=%b busy=%b cnt=%0d want 0/0/1", if1.rsp_valid, busy1, cnt1); else passed++;
    endtask

    task automatic test_decode();
        logic [3:0] ctr, rtag; logic [31:0] res; logic zero; int lat;
        vecs[0] = '{3'b000, 1'b1, 1'b1, 1'b0, 32'd5,        32'd7,        4'b0000, 32'd12};
        vecs[1] = '{3'b101, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'd4,        4'b1101, 32'hF8000000};
        vecs[2] = '{3'b101, 1'b0, 1'b1, 1'b0, 32'h80000000, 32'd4,        4'b0101, 32'h08000000};
        vecs[3] = '{3'b011, 1'b0, 1'b0, 1'b0, 32'd1,        32'hFFFFFFFF, 4'b0011, 32'd1};
        vecs[4] = '{3'b000, 1'b1, 1'b0, 1'b1, 32'h0000FFFF, 32'h12345000, 4'b1111, 32'h12345000};
        for (int i = 0; i < 5; i++) begin
            op1(vecs[i].f3, vecs[i].f7b5, vecs[i].imm, vecs[i].lui, vecs[i].a, vecs[i].b,
                4'(i + 8), ctr, lat, res, zero, rtag);
            total++; if (ctr !== vecs[i].ctr) $display("FAIL decode_ctr[%0d]: got %b want %b", i, ctr, vecs[i].ctr); else passed++;
            total++; if ({res, rtag} !== {vecs[i].res, 4'(i + 8)}) $display("FAIL decode_rsp[%0d]: got %h/%h want %h/%h", i, res, rtag, vecs[i].res, 4'(i + 8)); else passed++;
            pop1();
        end
        total++; if (cnt1 !== 16'd6) $display("FAIL decode_op_count: got %0d want 6", cnt1); else passed++;
    endtask

    task automatic test_zero();
        logic [3:0] ctr, rtag; logic [31:0] res; logic zero; int lat;
        op1(3'b000, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h1234, 4'hA, ctr, lat, res, zero, rtag);
        total++; if ({res, zero, rtag} !== {32'd0, 1'b1, 4'hA}) $display("FAIL zero_rsp: got %h/%b/%h want 0/1/a", res, zero, rtag); else passed++;
        pop1();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ctr, rtag; logic [31:0] res; logic zero; int lat;
        op1(3'b111, 1'b0, 1'b0, 1'b0, 32'h0F0F, 32'h00FF, 4'd5, ctr, lat, res, zero, rtag);
        set_req1(3'b110, 1'b0, 1'b0, 1'b0, 32'h00F0, 32'h000F, 4'd6);
        if1.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({if1.rsp_valid, if1.rsp_result, if1.rsp_tag, if1.req_ready} !== {1'b1, 32'h0000000F, 4'd5, 1'b0})
                $display("FAIL bp_hold[%0d]: got v=%b r=%h t=%h rdy=%b want 1/0000000f/5/0", i, if1.rsp_valid, if1.rsp_result, if1.rsp_tag, if1.req_ready); else passed++;
        end
        if1.rsp_ready = 1'b1;
        #1;
        total++; if (if1.req_ready !== 1'b1) $display("FAIL bp_req_ready_follows: got %b want 1", if1.req_ready); else passed++;
        @(posedge clk); #1;
        if1.rsp_ready = 1'b0; if1.req_valid = 1'b0;
        @(negedge clk);
        total++; if ({if1.rsp_valid, busy1, if1.alu_ctr, if1.alu_a, cnt1} !== {1'b0, 1'b1, 4'b0110, 32'h00F0, 16'd8})
            $display("FAIL bp_no_bubble: got v=%b busy=%b ctr=%b a=%h cnt=%0d want 0/1/0110/000000f0/8", if1.rsp_valid, busy1, if1.alu_ctr, if1.alu_a, cnt1); else passed++;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if1.rsp_valid) begin lat = i; break; end
        end
        total++; if (lat !== 2) $display("FAIL bp_second_latency: got %0d want 2", lat); else passed++;
        total++; if ({if1.rsp_result, if1.rsp_tag} !== {32'h000000FF, 4'd6}) $display("FAIL bp_second_rsp: got %h/%h want 000000ff/6", if1.rsp_result, if1.rsp_tag); else passed++;
        pop1();
        total++; if (cnt1 !== 16'd9) $display("FAIL bp_op_count: got %0d want 9", cnt1); else passed++;
    endtask

    task automatic test_lat3();
        @(posedge clk); #1;
        if3.req_funct3 = 3'b000; if3.req_f7b5 = 1'b1; if3.req_is_imm = 1'b0; if3.req_is_lui = 1'b0;
        if3.req_a = 32'd100; if3.req_b = 32'd1; if3.req_tag = 4'd9;
        if3.req_valid = 1'b1;
        @(negedge clk);
        total++; if (if3.req_ready !== 1'b1) $display("FAIL lat3_req_ready: got %b want 1", if3.req_ready); else passed++;
        @(posedge clk); #1;
        if3.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({if3.alu_a, if3.alu_b, if3.alu_ctr, if3.rsp_valid} !== {32'd100, 32'd1, 4'b1000, 1'b0})
                $display("FAIL lat3_hold[%0d]: got a=%h b=%h c=%b v=%b want 64/1/1000/0", i, if3.alu_a, if3.alu_b, if3.alu_ctr, if3.rsp_valid); else passed++;
        end
        @(negedge clk);
        total++; if (if3.rsp_valid !== 1'b0) $display("FAIL lat3_not_early: got %b want 0", if3.rsp_valid); else passed++;
        @(negedge clk);
        total++; if ({if3.rsp_valid, if3.rsp_result, if3.rsp_zero, if3.rsp_tag} !== {1'b1, 32'h63, 1'b0, 4'd9})
            $display("FAIL lat3_rsp: got v=%b r=%h z=%b t=%h want 1/00000063/0/9", if3.rsp_valid, if3.rsp_result, if3.rsp_zero, if3.rsp_tag); else passed++;
        if3.rsp_ready = 1'b1;
        @(posedge clk); #1;
        if3.rsp_ready = 1'b0;
        @(negedge clk);
        total++; if ({if3.rsp_valid, busy3, cnt3} !== {1'b0, 1'b0, 16'd1}) $display("FAIL lat3_after_pop: got v=%b busy=%b cnt=%0d want 0/0/1", if3.rsp_valid, busy3, cnt3); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] ctr, rtag; logic [31:0] res; logic zero; int lat;
        logic seen;
        @(posedge clk); #1;
        set_req1(3'b000, 1'b1, 1'b0, 1'b0, 32'd9, 32'd4, 4'd7);
        if1.req_valid = 1'b1;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        @(negedge clk);
        total++; if (busy1 !== 1'b1) $display("FAIL mid_in_exec: got busy=%b want 1", busy1); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if ({if1.alu_ctr, if1.alu_a, busy1, if1.rsp_valid, cnt1} !== {4'd0, 32'd0, 1'b0, 1'b0, 16'd0})
            $display("FAIL mid_reset_outputs: got ctr=%b a=%h busy=%b v=%b cnt=%0d want 0/0/0/0/0", if1.alu_ctr, if1.alu_a, busy1, if1.rsp_valid, cnt1); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (if1.rsp_valid) seen = 1'b1;
        end
        total++; if ({seen, cnt1} !== {1'b0, 16'd0}) $display("FAIL mid_no_response: got seen=%b cnt=%0d want 0/0", seen, cnt1); else passed++;
        op1(3'b100, 1'b0, 1'b0, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 4'hC, ctr, lat, res, zero, rtag);
        total++; if ({ctr, res, rtag} !== {4'b0100, 32'hF0F0F0F0, 4'hC}) $display("FAIL mid_recover_rsp: got %b/%h/%h want 0100/f0f0f0f0/c", ctr, res, rtag); else passed++;
        total++; if (lat !== 2) $display("FAIL mid_recover_latency: got %0d want 2", lat); else passed++;
        pop1();
        total++; if (cnt1 !== 16'd1) $display("FAIL mid_recover_count: got %0d want 1", cnt1); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_sub();
        test_decode();
        test_zero();
        test_back_to_back();
        test_lat3();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog expired");
    end
endmodule
